// File: rtl/inst_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and the core's decoder.
// Holds opcode values, field bit positions, error codes and the encoder FSM states.
package inst_encoder_pkg;

  localparam int unsigned OpW  = 5;
  localparam int unsigned RegW = 5;

  // Opcodes
  localparam logic [OpW-1:0] OpAdd  = 5'd0;
  localparam logic [OpW-1:0] OpSub  = 5'd1;
  localparam logic [OpW-1:0] OpAnd  = 5'd2;
  localparam logic [OpW-1:0] OpOr   = 5'd3;
  localparam logic [OpW-1:0] OpXor  = 5'd4;
  localparam logic [OpW-1:0] OpShl  = 5'd5;
  localparam logic [OpW-1:0] OpShr  = 5'd6;
  localparam logic [OpW-1:0] OpCmp  = 5'd7;
  localparam logic [OpW-1:0] OpMov  = 5'd8;
  localparam logic [OpW-1:0] OpMovh = 5'd9;
  localparam logic [OpW-1:0] OpBr   = 5'd10;
  localparam logic [OpW-1:0] OpCall = 5'd11;
  localparam logic [OpW-1:0] OpRet  = 5'd12;
  localparam logic [OpW-1:0] OpHalt = 5'd13;

  // Field positions (LSB of each field)
  localparam int unsigned OpLsb       = 27;
  localparam int unsigned ZLsb        = 16;
  localparam int unsigned ALsb        = 5;
  localparam int unsigned BLsb        = 0;
  localparam int unsigned Imm16Lsb    = 0;
  localparam int unsigned CcLsb       = 10;
  localparam int unsigned NegBit      = 19;
  localparam int unsigned PredLsb     = 16;
  localparam int unsigned SmallImmBit = 26;
  localparam int unsigned SextBit     = 25;

  // Error codes
  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrOpcode   = 2'd1;
  localparam logic [1:0] ErrImmRange = 2'd2;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StMovh = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer and legality check.
// Ports:
//   op, z, a, b, imm, use_imm, neg, cc : request fields
//   word0        : first (or only) encoded word
//   word1        : MOVH word carrying imm[31:16] for a split MOV
//   needs_second : request expands to word0 followed by word1
//   err_code     : ErrNone, ErrOpcode or ErrImmRange
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  z,
  input  logic [4:0]  a,
  input  logic [4:0]  b,
  input  logic [31:0] imm,
  input  logic        use_imm,
  input  logic        neg,
  input  logic [2:0]  cc,
  output logic [31:0] word0,
  output logic [31:0] word1,
  output logic        needs_second,
  output logic [1:0]  err_code
);

  logic small_pos;  // 0..31
  logic small_neg;  // -16..-1
  logic off_ok;     // fits signed 16 bits
  logic hi_zero;

  assign small_pos = (imm[31:5] == '0);
  assign small_neg = &imm[31:4];
  assign off_ok    = (imm[31:15] == '0) || (&imm[31:15]);
  assign hi_zero   = (imm[31:16] == '0);

  always_comb begin
    word0                    = '0;
    word0[OpLsb +: OpW]      = op;
    word1                    = '0;
    word1[OpLsb +: OpW]      = OpMovh;
    word1[ZLsb +: RegW]      = z;
    word1[Imm16Lsb +: 16]    = imm[31:16];
    needs_second             = 1'b0;
    err_code                 = ErrNone;

    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr, OpCmp: begin
        word0[ZLsb +: RegW] = z;
        word0[ALsb +: RegW] = a;
        if (use_imm) begin
          word0[SmallImmBit]  = 1'b1;
          word0[BLsb +: RegW] = imm[4:0];
          if (small_pos) begin
            word0[SextBit] = 1'b0;
          end else if (small_neg) begin
            word0[SextBit] = 1'b1;
          end else begin
            err_code = ErrImmRange;
          end
        end else begin
          word0[BLsb +: RegW] = b;
        end
        if (op == OpCmp) begin
          word0[CcLsb +: 3] = cc;
        end
      end
      OpMov: begin
        word0[ZLsb +: RegW]   = z;
        word0[Imm16Lsb +: 16] = imm[15:0];
        needs_second          = !hi_zero;
      end
      OpMovh: begin
        word0[ZLsb +: RegW]   = z;
        word0[Imm16Lsb +: 16] = imm[15:0];
        if (!hi_zero) begin
          err_code = ErrImmRange;
        end
      end
      OpBr: begin
        word0[NegBit]         = neg;
        word0[PredLsb +: 3]   = a[2:0];
        word0[Imm16Lsb +: 16] = imm[15:0];
        if (!off_ok) begin
          err_code = ErrImmRange;
        end
      end
      OpCall: begin
        word0[Imm16Lsb +: 16] = imm[15:0];
        if (!off_ok) begin
          err_code = ErrImmRange;
        end
      end
      OpRet, OpHalt: begin
      end
      default: begin
        err_code = ErrOpcode;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: turns field-level requests into 32-bit instruction words and
// streams them, tagged with a sequential write address, to the instruction-memory loader.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : request handshake and fields
//   out_valid/ready     : output handshake; out_inst/out_addr are the word and its address
//   base_load/base_addr : restart the address counter (only when idle and not mid-MOV)
//   err_valid/err_code  : one-cycle error pulse; code holds its last value
//   done                : HALT emitted and drained
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_z,
  input  logic [4:0]        req_a,
  input  logic [4:0]        req_b,
  input  logic [31:0]       req_imm,
  input  logic              req_use_imm,
  input  logic              req_neg,
  input  logic [2:0]        req_cc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic              done
);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [31:0]         movh_q, movh_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [31:0] pk_word0;
  logic [31:0] pk_word1;
  logic        pk_two;
  logic [1:0]  pk_err;
  logic        accept;
  logic        base_take;

  inst_pack u_pack (
    .op           (req_op),
    .z            (req_z),
    .a            (req_a),
    .b            (req_b),
    .imm          (req_imm),
    .use_imm      (req_use_imm),
    .neg          (req_neg),
    .cc           (req_cc),
    .word0        (pk_word0),
    .word1        (pk_word1),
    .needs_second (pk_two),
    .err_code     (pk_err)
  );

  assign req_ready = !rst && (state_q == StRun) && !base_load && (!out_valid_q || out_ready);
  assign accept    = req_valid && req_ready;
  // Never restart mid-stream: the pending word or MOVH would land at the wrong address.
  assign base_take = base_load && !out_valid_q && (state_q != StMovh);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    next_addr_d = next_addr_q;
    movh_d      = movh_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      StRun: begin
        if (accept) begin
          if (pk_err != ErrNone) begin
            err_valid_d = 1'b1;
            err_code_d  = pk_err;
          end else begin
            out_valid_d = 1'b1;
            out_inst_d  = pk_word0;
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + ADDR_W'(1);
            if (pk_two) begin
              movh_d  = pk_word1;
              state_d = StMovh;
            end else if (req_op == OpHalt) begin
              state_d = StDone;
            end
          end
        end
      end
      StMovh: begin
        // out_valid is always set here; the MOVH follows as soon as the MOV leaves.
        if (out_ready) begin
          out_valid_d = 1'b1;
          out_inst_d  = movh_q;
          out_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + ADDR_W'(1);
          state_d     = StRun;
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StRun;
      end
    endcase

    if (base_take) begin
      next_addr_d = base_addr;
      state_d     = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      next_addr_q <= '0;
      movh_q      <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ErrNone;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      next_addr_q <= next_addr_d;
      movh_q      <= movh_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign done      = (state_q == StDone) && !out_valid_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder with a transaction-level reference model.
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op, req_z, req_a, req_b;
  logic [31:0]   req_imm;
  logic          req_use_imm, req_neg;
  logic [2:0]    req_cc;
  logic          out_valid, out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          err_valid;
  logic [1:0]    err_code;
  logic          done;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_z       (req_z),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_imm     (req_imm),
    .req_use_imm (req_use_imm),
    .req_neg     (req_neg),
    .req_cc      (req_cc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_addr    (out_addr),
    .base_load   (base_load),
    .base_addr   (base_addr),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .done        (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    bit          split_first;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_next;
  bit          m_halted;
  bit          m_movh_pend;
  bit          exp_err_pulse;
  logic [1:0]  exp_err_code;
  bit          hold_pend;
  logic [31:0] hold_inst, hold_addr;
  bit          last_accept;

  // Encoding rules written as value ranges and field arithmetic.
  function automatic void model_encode(input logic [4:0] op, z, a, b, input logic [31:0] imm,
                                       input logic use_imm, neg, input logic [2:0] cc,
                                       output logic [1:0] err, output logic [31:0] w0, w1,
                                       output bit two);
    int          s;
    int unsigned u;
    s   = $signed(imm);
    u   = imm;
    err = 2'd0;
    two = 1'b0;
    w0  = 32'(op) << 27;
    w1  = (32'(OpMovh) << 27) | (32'(z) << 16) | (u >> 16);
    if (op inside {OpAdd, OpSub, OpAnd, OpOr, OpXor, OpShl, OpShr, OpCmp}) begin
      w0 = w0 | (32'(z) << 16) | (32'(a) << 5);
      if (use_imm) begin
        if (s < -16 || s > 31) err = 2'd2;
        else w0 = w0 | (32'd1 << 26) | ((s < 0) ? (32'd1 << 25) : 32'd0) | (u % 32);
      end else begin
        w0 = w0 | 32'(b);
      end
      if (op == OpCmp) w0 = w0 | (32'(cc) << 10);
    end else if (op == OpMov) begin
      w0  = w0 | (32'(z) << 16) | (u % 65536);
      two = (u > 65535);
    end else if (op == OpMovh) begin
      if (u > 65535) err = 2'd2;
      else w0 = w0 | (32'(z) << 16) | u;
    end else if (op == OpBr) begin
      if (s < -32768 || s > 32767) err = 2'd2;
      else w0 = w0 | (32'(neg) << 19) | (32'(a % 8) << 16) | (u % 65536);
    end else if (op == OpCall) begin
      if (s < -32768 || s > 32767) err = 2'd2;
      else w0 = w0 | (u % 65536);
    end else if (op == OpRet || op == OpHalt) begin
      w0 = w0;
    end else begin
      err = 2'd1;
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_next        = 0;
    m_halted      = 1'b0;
    m_movh_pend   = 1'b0;
    exp_err_pulse = 1'b0;
    hold_pend     = 1'b0;
  endtask

  task automatic model_accept();
    logic [1:0]  err;
    logic [31:0] w0, w1;
    bit          two;
    model_encode(req_op, req_z, req_a, req_b, req_imm, req_use_imm, req_neg, req_cc,
                 err, w0, w1, two);
    if (err != 2'd0) begin
      exp_err_pulse = 1'b1;
      exp_err_code  = err;
    end else begin
      exp_q.push_back('{inst: w0, addr: m_next, split_first: two});
      m_next = (m_next + 1) % (1 << AW);
      if (two) begin
        exp_q.push_back('{inst: w1, addr: m_next, split_first: 1'b0});
        m_next      = (m_next + 1) % (1 << AW);
        m_movh_pend = 1'b1;
      end
      if (req_op == OpHalt) m_halted = 1'b1;
    end
  endtask

  // One clock: called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    bit   exp_rdy;
    bit   base_ok;
    exp_t e;
    #1;
    check_eq("err_valid", 32'(err_valid), 32'(exp_err_pulse));
    if (exp_err_pulse) check_eq("err_code", 32'(err_code), 32'(exp_err_code));
    exp_err_pulse = 1'b0;
    check_eq("done", 32'(done), 32'(m_halted && exp_q.size() == 0));
    check_eq("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    exp_rdy = !rst && !base_load && (exp_q.size() == 0 || out_ready) && !m_movh_pend && !m_halted;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (hold_pend && out_valid) begin
      check_eq("hold_inst", out_inst, hold_inst);
      check_eq("hold_addr", 32'(out_addr), hold_addr);
    end
    hold_pend = out_valid && !out_ready;
    hold_inst = out_inst;
    hold_addr = 32'(out_addr);
    base_ok   = base_load && exp_q.size() == 0 && !m_movh_pend;
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_word", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_inst", out_inst, e.inst);
        check_eq("out_addr", 32'(out_addr), e.addr);
        if (e.split_first) m_movh_pend = 1'b0;
      end
    end
    last_accept = req_valid && req_ready && !rst;
    if (last_accept) model_accept();
    if (base_ok && !rst) begin
      m_next   = 32'(base_addr);
      m_halted = 1'b0;
    end
    if (rst) model_reset();
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] op, z, a, b, input logic [31:0] imm,
                      input logic use_imm, neg, input logic [2:0] cc);
    bit acc;
    acc         = 1'b0;
    req_op      = op;
    req_z       = z;
    req_a       = a;
    req_b       = b;
    req_imm     = imm;
    req_use_imm = use_imm;
    req_neg     = neg;
    req_cc      = cc;
    req_valid   = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      tick();
      acc = last_accept;
    end
    req_valid = 1'b0;
    check_eq("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    req_valid = 1'b0;
    base_load = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 51)) - 32'd20;
      1:       return 32'($urandom_range(0, 131071)) - 32'd65536;
      2:       return 32'($urandom);
      default: return 32'($urandom_range(0, 131071));
    endcase
  endfunction

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_z = '0; req_a = '0; req_b = '0;
    req_imm = '0; req_use_imm = 1'b0; req_neg = 1'b0; req_cc = '0;
    out_ready = 1'b1; base_load = 1'b0; base_addr = '0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_out_inst", out_inst, 32'd0);
    check_eq("rst_out_addr", 32'(out_addr), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);

    // Register form ADD, small-immediate SUB, then out-of-range immediate
    send(OpAdd, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b0, 3'd0);
    check_eq("t1_inst", out_inst, (32'(OpAdd) << 27) | 32'h0003_0022);
    check_eq("t1_addr", 32'(out_addr), 32'd0);
    send(OpSub, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFD, 1'b1, 1'b0, 3'd0);
    check_eq("t2_inst", out_inst, (32'(OpSub) << 27) | 32'h0601_005D);
    send(OpSub, 5'd1, 5'd2, 5'd0, 32'd40, 1'b1, 1'b0, 3'd0);
    send(OpCmp, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0, 1'b0, 3'd5);

    // Split MOV with a stalled consumer
    send(OpMov, 5'd4, 5'd0, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 3'd0);
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("t3_mov_lo", out_inst, (32'(OpMov) << 27) | 32'h0004_5678);
    out_ready = 1'b1;
    tick();
    check_eq("t3_movh", out_inst, (32'(OpMovh) << 27) | 32'h0004_1234);
    send(OpMov, 5'd4, 5'd0, 5'd0, 32'h0000_8000, 1'b0, 1'b0, 3'd0);

    // Branches and an undefined opcode
    send(OpBr, 5'd0, 5'd2, 5'd0, 32'hFFFF_FFF8, 1'b0, 1'b1, 3'd0);
    check_eq("t4_br", out_inst, (32'(OpBr) << 27) | 32'h000A_FFF8);
    send(OpBr, 5'd0, 5'd2, 5'd0, 32'h0001_0000, 1'b0, 1'b1, 3'd0);
    send(5'd20, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 3'd0);
    drain();

    // Random traffic
    for (int cyc = 0; cyc < 800; cyc++) begin
      int k;
      k         = $urandom_range(0, 99);
      req_valid = ($urandom_range(0, 9) < 7);
      if (k < 5) req_op = 5'($urandom_range(14, 31));
      else if (k < 7) req_op = OpHalt;
      else req_op = 5'($urandom_range(0, 12));
      req_z       = 5'($urandom);
      req_a       = 5'($urandom);
      req_b       = 5'($urandom);
      req_imm     = rand_imm();
      req_use_imm = 1'($urandom);
      req_neg     = 1'($urandom);
      req_cc      = 3'($urandom);
      out_ready   = ($urandom_range(0, 9) < 7);
      base_load   = ($urandom_range(0, 11) == 0);
      base_addr   = AW'($urandom);
      tick();
    end
    drain();

    // HALT, drain, then restart at the top of the address space
    base_load = 1'b1;
    base_addr = '0;
    tick();
    base_load = 1'b0;
    send(OpHalt, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0);
    repeat (3) tick();
    check_eq("t5_done", 32'(done), 32'd1);
    base_load = 1'b1;
    base_addr = AW'(10'h3FF);
    tick();
    base_load = 1'b0;
    check_eq("t5_done_clr", 32'(done), 32'd0);
    send(OpAdd, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 3'd0);
    check_eq("t5_addr_top", 32'(out_addr), 32'h3FF);
    send(OpAdd, 5'd4, 5'd5, 5'd6, 32'd0, 1'b0, 1'b0, 3'd0);
    check_eq("t5_addr_wrap", 32'(out_addr), 32'd0);
    drain();

    // Reset while the MOVH is still pending
    out_ready = 1'b0;
    send(OpMov, 5'd9, 5'd0, 5'd0, 32'hABCD_1234, 1'b0, 1'b0, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_valid", 32'(out_valid), 32'd0);
    check_eq("t6_addr", 32'(out_addr), 32'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    send(OpAdd, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 3'd0);
    check_eq("t6_first_addr", 32'(out_addr), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
